// File: rtl/prog_clock_divider_if.sv
// Control and status bundle for prog_clock_divider.
// The master side (host) drives the run enable, settings strobe and sync
// strobe. The slave side (divider) returns the divided clock and status flags.
interface prog_clock_divider_if #(
  parameter int BITS = 8
);
  logic            en;       // run enable; low parks out low
  logic            load;     // one-cycle strobe that captures div_in/high_in
  logic [BITS-1:0] div_in;   // requested period in clk cycles
  logic [BITS-1:0] high_in;  // requested high time in clk cycles, 0 = half period
  logic            sync;     // phase-realign strobe
  logic            out;      // registered divided clock
  logic            tick;     // one-cycle pulse at each period start
  logic            pending;  // captured settings not yet applied

  modport master (
    output en, load, div_in, high_in, sync,
    input  out, tick, pending
  );

  modport slave (
    input  en, load, div_in, high_in, sync,
    output out, tick, pending
  );
endinterface

// File: rtl/prog_clock_divider.sv
// Programmable clock divider with glitch-free registered output.
// New period/high-time settings are captured into a shadow register and
// become active only when a period restarts, so a running period is never
// cut short or stretched by a settings change.
module prog_clock_divider #(
  parameter int BITS         = 8,
  parameter int DEFAULT_DIV  = 32,
  parameter int DEFAULT_HIGH = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  prog_clock_divider_if.slave    bus
);

  localparam logic [BITS-1:0] DEF_DIV  = BITS'(DEFAULT_DIV);
  localparam logic [BITS-1:0] DEF_HIGH = BITS'(DEFAULT_HIGH);
  localparam logic [BITS-1:0] MIN_DIV  = BITS'(2);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic            out_q, out_d;
  logic            tick_q, tick_d;

  logic [BITS-1:0] act_div_q, act_div_d;
  logic [BITS-1:0] act_high_q, act_high_d;
  logic [BITS-1:0] sh_div_q, sh_div_d;
  logic [BITS-1:0] sh_high_q, sh_high_d;
  logic            pending_q, pending_d;

  logic [BITS-1:0] d_eff;
  logic [BITS-1:0] d_last;
  logic [BITS-1:0] h_eff;
  logic [BITS:0]   cnt_inc;
  logic            terminal;
  logic            restart;
  logic            apply;

  // Effective period/high time from the active settings. Periods below 2
  // cannot toggle, so they are clamped to 2; the high time is clamped into
  // 1..d_eff-1 so the output always has both a high and a low phase.
  always_comb begin
    d_eff    = (act_div_q < MIN_DIV) ? MIN_DIV : act_div_q;
    d_last   = d_eff - BITS'(1);
    if (act_high_q == '0) begin
      h_eff = d_eff >> 1;
    end else if (act_high_q > d_last) begin
      h_eff = d_last;
    end else begin
      h_eff = act_high_q;
    end
    // One extra bit so the compare against h_eff cannot wrap.
    cnt_inc  = {1'b0, cnt_q} + {{BITS{1'b0}}, 1'b1};
    terminal = (cnt_q == d_last);
  end

  // Next state, counter and output bits. Priority: disable, then sync, then
  // terminal count, then plain increment. out_d is the level for the cycle
  // after the edge, so out itself is purely a flop output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    tick_d  = 1'b0;
    restart = 1'b0;

    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      out_d   = 1'b0;
      tick_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = RUN;
          cnt_d   = '0;
          out_d   = 1'b1;
          tick_d  = 1'b1;
          restart = 1'b1;
        end
        RUN: begin
          if (bus.sync || terminal) begin
            cnt_d   = '0;
            out_d   = 1'b1;
            tick_d  = 1'b1;
            restart = 1'b1;
          end else begin
            cnt_d   = cnt_inc[BITS-1:0];
            out_d   = (cnt_inc < {1'b0, h_eff});
            tick_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          out_d   = 1'b0;
          tick_d  = 1'b0;
        end
      endcase
    end
  end

  // Settings path. The shadow is pushed to the active registers only at a
  // period restart or while idle. A load on the same edge goes into the
  // shadow and waits for the next restart, so pending stays set.
  always_comb begin
    apply      = (state_q == IDLE) || restart;
    act_div_d  = apply ? sh_div_q  : act_div_q;
    act_high_d = apply ? sh_high_q : act_high_q;
    sh_div_d   = bus.load ? bus.div_in  : sh_div_q;
    sh_high_d  = bus.load ? bus.high_in : sh_high_q;
    if (bus.load) begin
      pending_d = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // FSM/counter/output registers. Reset clears out asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
    end
  end

  // Active/shadow settings registers. Reset restores the defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_div_q  <= DEF_DIV;
      act_high_q <= DEF_HIGH;
      sh_div_q   <= DEF_DIV;
      sh_high_q  <= DEF_HIGH;
      pending_q  <= 1'b0;
    end else begin
      act_div_q  <= act_div_d;
      act_high_q <= act_high_d;
      sh_div_q   <= sh_div_d;
      sh_high_q  <= sh_high_d;
      pending_q  <= pending_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.tick    = tick_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Testbench for prog_clock_divider: directed scenarios plus a randomized run.
// An abstract period/phase model predicts out/tick/pending on every edge.
module tb_prog_clock_divider;
  localparam int BITS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prog_clock_divider_if #(.BITS(BITS)) bus ();

  prog_clock_divider #(
    .BITS(BITS),
    .DEFAULT_DIV(32),
    .DEFAULT_HIGH(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: is the divider running, where are we inside the period,
  // and what settings are active/shadowed.
  bit m_run;
  int m_pos;
  int m_adiv, m_ahigh, m_sdiv, m_shigh;
  bit m_pend, m_out, m_tick;

  function automatic int deff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int heff(input int d, input int h);
    int de;
    de = deff(d);
    if (h == 0) return de / 2;
    return (h < de - 1) ? h : de - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_out = 0; m_tick = 0; m_pend = 0;
    m_adiv = 32; m_ahigh = 0; m_sdiv = 32; m_shigh = 0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    bit restart, apply;
    restart = bus.en && (!m_run || bus.sync || (m_pos == deff(m_adiv) - 1));
    apply   = !m_run || restart;
    if (apply) begin
      m_adiv  = m_sdiv;
      m_ahigh = m_shigh;
    end
    if (!bus.en) begin
      m_run = 0; m_pos = 0; m_tick = 0;
    end else if (restart) begin
      m_run = 1; m_pos = 0; m_tick = 1;
    end else begin
      m_pos++; m_tick = 0;
    end
    m_out = m_run && (m_pos < heff(m_adiv, m_ahigh));
    if (bus.load) begin
      m_sdiv = int'(bus.div_in); m_shigh = int'(bus.high_in); m_pend = 1;
    end else if (apply) begin
      m_pend = 0;
    end
  endtask

  // Advance one clock, update model, compare just after the edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    chk("out", bus.out, m_out);
    chk("tick", bus.tick, m_tick);
    chk("pending", bus.pending, m_pend);
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (bus.tick !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_tick_timeout"}, (n >= 400) ? 1 : 0, 0);
  endtask

  // Measures the next complete period (tick to tick) and its high time.
  task automatic measure(input int exp_per, input int exp_hi, input string tag);
    int per, hi;
    step();
    wait_tick(tag);
    per = 0; hi = 0;
    do begin
      if (bus.out === 1'b1) hi++;
      per++;
      step();
    end while (bus.tick !== 1'b1 && per < 400);
    $display("measure %s: period=%0d high=%0d", tag, per, hi);
    chk({tag, "_period"}, per, exp_per);
    chk({tag, "_high"}, hi, exp_hi);
  endtask

  initial begin
    int n, per, hi;
    bus.en = 0; bus.load = 0; bus.sync = 0; bus.div_in = '0; bus.high_in = '0;
    model_reset();

    // Reset state
    #12;
    chk("rst_out", bus.out, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_pending", bus.pending, 0);
    step();
    #1 rst = 0;
    step();
    step();

    // Defaults: 16 high / 16 low, tick every 32
    bus.en = 1;
    measure(32, 16, "default_a");
    measure(32, 16, "default_b");

    // Load mid-period: current 32-cycle period completes, then 5/2
    for (int i = 0; i < 7; i++) step();
    bus.load = 1; bus.div_in = 8'd5; bus.high_in = 8'd0;
    step();
    bus.load = 0;
    chk("load_mid_pending", bus.pending, 1);
    n = 0;
    while (bus.tick !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    $display("load_mid: edges to restart=%0d", n);
    chk("load_mid_remaining", n, 24);
    measure(5, 2, "div5");
    chk("div5_pending_clear", bus.pending, 0);

    // div 1 loaded while idle -> period 2; then 5 with high clamped to 4
    bus.en = 0;
    step();
    bus.load = 1; bus.div_in = 8'd1; bus.high_in = 8'd0;
    step();
    bus.load = 0;
    bus.en = 1;
    measure(2, 1, "div1");
    bus.load = 1; bus.div_in = 8'd5; bus.high_in = 8'd9;
    step();
    bus.load = 0;
    measure(5, 4, "div5_h9");

    // Sync mid-period, sync while disabled
    bus.load = 1; bus.div_in = 8'd32; bus.high_in = 8'd0;
    step();
    bus.load = 0;
    measure(32, 16, "back_to_32");
    for (int i = 0; i < 10; i++) step();
    bus.sync = 1;
    step();
    bus.sync = 0;
    chk("sync_tick", bus.tick, 1);
    chk("sync_out", bus.out, 1);
    bus.en = 0; bus.sync = 1;
    step();
    bus.sync = 0;
    chk("sync_dis_out", bus.out, 0);
    chk("sync_dis_tick", bus.tick, 0);
    for (int i = 0; i < 3; i++) step();

    // Asynchronous reset while out is high
    bus.en = 1;
    wait_tick("pre_rst");
    bus.load = 1; bus.div_in = 8'd9; bus.high_in = 8'd3;
    step();
    bus.load = 0;
    chk("pre_rst_out", bus.out, 1);
    #3 rst = 1;
    model_reset();
    #1;
    chk("async_rst_out", bus.out, 0);
    chk("async_rst_tick", bus.tick, 0);
    chk("async_rst_pending", bus.pending, 0);
    step();
    #3 rst = 0;
    measure(32, 16, "after_rst");

    // Load coincident with terminal count: old period repeats once
    for (int i = 0; i < 31; i++) step();
    bus.load = 1; bus.div_in = 8'd6; bus.high_in = 8'd0;
    step();
    bus.load = 0;
    chk("term_load_tick", bus.tick, 1);
    chk("term_load_pending", bus.pending, 1);
    per = 0; hi = 0;
    do begin
      if (bus.out === 1'b1) hi++;
      per++;
      step();
    end while (bus.tick !== 1'b1 && per < 400);
    $display("term_load repeat: period=%0d high=%0d", per, hi);
    chk("term_repeat_period", per, 32);
    chk("term_repeat_high", hi, 16);
    measure(6, 3, "term_new");

    // Randomized run against the model
    for (int c = 0; c < 1500; c++) begin
      bus.en   = ($urandom_range(0, 99) >= 4);
      bus.load = ($urandom_range(0, 99) < 8);
      if (bus.load) begin
        bus.div_in  = BITS'($urandom_range(0, 12));
        bus.high_in = BITS'($urandom_range(0, 12));
      end
      bus.sync = ($urandom_range(0, 99) < 3);
      step();
      bus.load = 0; bus.sync = 0;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1;
        model_reset();
        #1;
        chk("rand_async_rst_out", bus.out, 0);
        step();
        #2 rst = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 SHALL have parameter BITS, default 8, width of divisor, high-time and counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 32, reset value of the active period, in clk cycles.
REQ-003 SHALL have parameter DEFAULT_HIGH, default 0, reset value of the active high time (0 = 50% duty).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port en, input, 1, run enable; low = output parked low.
REQ-007 SHALL have port load, input, 1, single-cycle strobe capturing div_in/high_in.
REQ-008 SHALL have port div_in, input, BITS, requested period in clk cycles.
REQ-009 SHALL have port high_in, input, BITS, requested high time in clk cycles (0 = half period).
REQ-010 SHALL have port sync, input, 1, phase-realign strobe; restarts the period.
REQ-011 SHALL have port out, output, 1, registered divided clock.
REQ-012 SHALL have port tick, output, 1, registered one-cycle pulse at each period start.
REQ-013 SHALL have port pending, output, 1, high while captured settings await application.

Function
REQ-014 SHALL hold active regs act_div, act_high, shadow regs sh_div, sh_high, counter cnt (BITS), state IDLE/RUN.
REQ-015 SHALL derive d_eff = max(act_div, 2), i.e. act_div of 0 or 1 is treated as 2.
REQ-016 SHALL derive h_eff = d_eff>>1 when act_high==0, else min(act_high, d_eff-1); h_eff is therefore always in 1..d_eff-1.
REQ-017 SHALL, in IDLE, hold cnt=0, out=0, tick=0.
REQ-018 SHALL, on a clk edge in IDLE with en=1, go to RUN with cnt<=0, out<=1, tick<=1.
REQ-019 SHALL, on a clk edge in RUN with en=1, when sync=1 or cnt==d_eff-1, set cnt<=0, out<=1, tick<=1 (period restart).
REQ-020 SHALL otherwise, in RUN, set cnt<=cnt+1, out<=(cnt+1 < h_eff), tick<=0.
REQ-021 SHALL, on a clk edge with en=0, go to IDLE with cnt<=0, out<=0, tick<=0, regardless of sync.
REQ-022 SHALL, on load=1, capture sh_div<=div_in, sh_high<=high_in and set pending<=1; a later load before application overwrites the shadow.
REQ-023 SHALL apply the shadow (act<=sh, pending<=0) only on a period restart (REQ-018/REQ-019) or on any edge in IDLE, so a period never changes mid-cycle.
REQ-024 SHALL, when load coincides with a period restart, restart the period with the old active values and apply the new shadow at the following restart (pending=1 meanwhile).
REQ-025 SHALL give priority rst > en=0 > sync > terminal count > increment.
REQ-026 SHALL produce period d_eff and high time h_eff exactly; the maximum period is 2^BITS-1 cycles, with no counter overflow.
REQ-027 SHALL keep out glitch-free: out is driven only from a flop, never from combinational logic.

Reset
REQ-028 SHALL, while rst=1, force asynchronously: state=IDLE, cnt=0, out=0, tick=0, pending=0, act_div=sh_div=DEFAULT_DIV, act_high=sh_high=DEFAULT_HIGH.
REQ-029 SHALL, on rst asserted mid-period, drop out to 0 without waiting for a clk edge; after release, behaviour is per REQ-018.

Verification
REQ-030 SHALL cover: reset, then en=1 with defaults -> out 16 cycles high / 16 low, tick every 32 cycles, coincident with out rising.
REQ-031 SHALL cover: load div_in=5, high_in=0 at cnt=7 of a default period -> pending=1; current 32-cycle period completes; then period 5, high 2, pending=0.
REQ-032 SHALL cover: load div_in=1 while IDLE, then en=1 -> period 2, out alternating 1/0 each cycle; div_in=5, high_in=9 -> high 4, low 1.
REQ-033 SHALL cover: sync at cnt=10 -> next edge cnt=0, out=1, tick=1; sync with en=0 -> no effect, out stays 0.
REQ-034 SHALL cover: rst pulsed between clk edges while out=1 -> out=0 immediately; defaults restored; load coincident with terminal count -> old period repeats once, new one after.
